// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the MDU op encodings, FSM states and default latencies.
package e_mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MADD  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// Handshake bundle between the E stage / hazard unit and the MDU.
// master: pipeline side (drives start/op/operands/D_md_use);
// slave: MDU side (drives busy, HI, LO and the stall request).
interface e_mdu_ctrl_if;

    logic        E_start;
    logic [2:0]  E_mdu_op;
    logic [31:0] E_data1;
    logic [31:0] E_data2;
    logic        D_md_use;
    logic        E_busy;
    logic [31:0] E_hi;
    logic [31:0] E_lo;
    logic        E_md_stall;

    modport master (
        output E_start,
        output E_mdu_op,
        output E_data1,
        output E_data2,
        output D_md_use,
        input  E_busy,
        input  E_hi,
        input  E_lo,
        input  E_md_stall
    );

    modport slave (
        input  E_start,
        input  E_mdu_op,
        input  E_data1,
        input  E_data2,
        input  D_md_use,
        output E_busy,
        output E_hi,
        output E_lo,
        output E_md_stall
    );

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: multiply, divide and multiply-accumulate.
// Ports: op, a (rs), b (rt), hi_in/lo_in (accumulate base / hold value)
// -> res_hi, res_lo, div_zero. MADD arithmetic is always present here;
// whether op 110 is accepted is decided by MDU_MADD_EN in e_mdu_ctrl.
module e_mdu_calc
    import e_mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    always_comb begin
        // Sign-extend to 64 bits; the low 64 bits of the product are
        // the exact two's-complement result.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        acc    = {hi_in, lo_in} + prod_s;

        // Divisor forced non-zero so the divider never produces X;
        // the result is discarded in that case anyway.
        div_zero = (b == 32'd0);
        b_safe   = div_zero ? 32'd1 : b;

        // Signed divide on magnitudes: quotient truncates toward zero,
        // remainder takes the dividend's sign. 0x80000000 / -1 wraps
        // back to 0x80000000 with remainder 0.
        a_mag = a[31] ? (32'd0 - a) : a;
        b_mag = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        q_s   = (a[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = a[31] ? (32'd0 - r_mag) : r_mag;

        q_u = a / b_safe;
        r_u = a % b_safe;

        res_hi = hi_in;
        res_lo = lo_in;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV:   begin
                res_hi = r_s;
                res_lo = q_s;
            end
            MD_DIVU:  begin
                res_hi = r_u;
                res_lo = q_u;
            end
            MD_MADD:  {res_hi, res_lo} = acc;
            default:  ;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multi-cycle MDU controller: owns HI/LO, runs a fixed-latency
// busy window per MULT/MULTU/DIV/DIVU and raises the MDU stall request.
// Ports: clk, reset (sync, active-high), mdu (e_mdu_ctrl_if.slave:
// E_start, E_mdu_op, E_data1, E_data2, D_md_use in; E_busy, E_hi, E_lo,
// E_md_stall out). Optional feature macro: MDU_MADD_EN (accepts op 110).
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    e_mdu_ctrl_if.slave   mdu
);

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div_zero;
    logic        busy;
    logic        long_op;
    logic        is_div;

    e_mdu_calc u_calc (
        .op       (mdu.E_mdu_op),
        .a        (mdu.E_data1),
        .b        (mdu.E_data2),
        .hi_in    (hi_q),
        .lo_in    (lo_q),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_div_zero)
    );

    assign busy = (state_q == S_BUSY);
    assign is_div = (mdu.E_mdu_op == MD_DIV) || (mdu.E_mdu_op == MD_DIVU);

`ifdef MDU_MADD_EN
    assign long_op = (mdu.E_mdu_op == MD_MULT)  ||
                     (mdu.E_mdu_op == MD_MULTU) ||
                     (mdu.E_mdu_op == MD_MADD)  ||
                     is_div;
`else
    assign long_op = (mdu.E_mdu_op == MD_MULT)  ||
                     (mdu.E_mdu_op == MD_MULTU) ||
                     is_div;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        unique case (state_q)
            S_IDLE: begin
                if (mdu.E_start) begin
                    if (long_op) begin
                        pend_hi_d = calc_hi;
                        pend_lo_d = calc_lo;
                        // Divide by zero still runs the window but
                        // leaves HI/LO untouched at commit.
                        pend_wr_d = !(is_div && calc_div_zero);
                        cnt_d     = is_div ? DIV_LAT : MULT_LAT;
                        state_d   = S_BUSY;
                    end else if (mdu.E_mdu_op == MD_MTHI) begin
                        hi_d = mdu.E_data1;
                    end else if (mdu.E_mdu_op == MD_MTLO) begin
                        lo_d = mdu.E_data1;
                    end
                end
            end
            S_BUSY: begin
                // Starts while busy are ignored; the hazard unit
                // is expected to prevent them.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign mdu.E_busy     = busy;
    assign mdu.E_hi       = hi_q;
    assign mdu.E_lo       = lo_q;
    assign mdu.E_md_stall = mdu.D_md_use & (mdu.E_start | busy);

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
E-stage multi-cycle multiply/divide controller for the pipelined MIPS core; sits beside E_ALU.
- Accepts MDU instructions from E and sequences a fixed-latency busy window.
- Owns the HI/LO architectural registers.
- Generates the MDU stall request consumed by the hazard unit.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
E_start  input  1  E-stage instruction is an MDU op this cycle (one-cycle pulse per instruction)
E_mdu_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD (optional), 111 reserved
E_data1  input  32  forwarded rs value
E_data2  input  32  forwarded rt value
D_md_use  input  1  D-stage instruction reads or writes the MDU (mult/div/mfhi/mflo/mthi/mtlo)
E_busy  output  1  MDU operation in progress
E_hi  output  32  current HI
E_lo  output  32  current LO
E_md_stall  output  1  stall request = D_md_use & (E_start | E_busy), combinational

Behaviour:
Reset:
- Synchronous; on reset=1 at a rising edge: state IDLE, counter 0, E_busy 0, HI 0, LO 0, pending results 0.
- Reset mid-operation aborts the operation; no commit occurs.

FSM, two states, IDLE and BUSY:
- IDLE, E_start=1, op in {MULT, MULTU, DIV, DIVU}: latch the result into pending_hi/pending_lo, load counter with the latency, go to BUSY.
- IDLE, E_start=1, op MTHI/MTLO: write E_data1 to HI/LO at that edge; stay IDLE; E_busy stays 0.
- BUSY: decrement the counter each cycle. At the edge where counter==1: commit pending values to HI/LO, go to IDLE.

Timing:
- Start sampled at edge T: E_busy=1 for exactly N cycles (T+1 .. T+N).
- HI/LO show new values, and E_busy=0, from T+N.
- Back-to-back start is accepted on the first cycle E_busy=0.

Arithmetic:
- MULT: {HI,LO} = signed 32x32 -> 64.
- MULTU: {HI,LO} = unsigned 32x32 -> 64.
- DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: full busy window still runs; HI/LO keep their old values.

Boundary conditions:
- E_start while E_busy=1: ignored (the hazard unit forbids it). State, counter and pending values are unchanged.
- MTHI/MTLO while busy: ignored.
- Reserved op, or 110 without the optional feature: no-op.
- HI/LO change only on commit, MTHI/MTLO or reset.

Optional Feature:
MDU_MADD_EN
- Defined: op 110 MADD is accepted. {HI,LO} <= {HI,LO} + signed(E_data1*E_data2), mod 2^64.
- The accumulate base is the HI/LO value at start time. Latency is MULT_CYCLES.
- Undefined: op 110 is a no-op; E_busy is not raised.

Decomposition:
Shared package/header:
- MDU op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD.
- FSM state encodings S_IDLE, S_BUSY.
- Default latency constants.

Sub-module e_mdu_calc:
- Combinational; op, a, b, hi_in, lo_in -> res_hi, res_lo, div_zero.
- Keeps the arithmetic separate from the FSM and counter.

Test Plan:
- Reset, MULT 0xFFFFFFFF*0x00000002 -> E_busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV 0xFFFFFFF9(-7) / 2 -> E_busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> busy 10 cycles; HI/LO unchanged.
- MTHI 0x1234 while idle -> HI=0x1234 next cycle, E_busy stays 0. Start MULT during an active DIV -> ignored; DIV result commits on schedule.
- D_md_use=1 during E_start and during busy -> E_md_stall=1 each of those cycles; 0 after busy drops.
- Assert reset at busy cycle 4 of DIV -> next edge E_busy=0, HI=LO=0, no later commit.
